latq_bank_wr_sched: RTL and testbench

//  Write scheduler for a latch-based register bank built from the 7-track latq_* cells (positive-level E, D->Q).

---
 rtl/latq_bank_pkg.sv | 14 +
 rtl/latq_bank_rr_arb2.sv | 32 +++
 rtl/latq_bank_wr_sched.sv | 120 ++++++++++++
 tb/tb_latq_bank_wr_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/latq_bank_pkg.sv
// Shared types for the latch-bank write scheduler.
// Write sequence states and the per-write cycle count.
package latq_bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wr_state_e;

    localparam int LATQ_WR_LAT = 4;

endpackage

// File: rtl/latq_bank_rr_arb2.sv
// Two-way round-robin arbiter for the latch-bank write scheduler.
// The pointer remembers the last granted requester and moves only on accept.
module latq_bank_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // last = 1 means requester 1 won most recently, so requester 0 goes next
    logic last;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/latq_bank_wr_sched.sv
// Write scheduler driving a latch bank: SETUP/STROBE/HOLD around a one-hot enable.
// Optional even parity on the data bus when LATQ_WR_PARITY_EN is defined.
module latq_bank_wr_sched
    import latq_bank_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    parameter  int DATA_W      = 8,
    localparam int ADDR_W      = $clog2(NUM_ENTRIES),
`ifdef LATQ_WR_PARITY_EN
    localparam int LD_W        = DATA_W + 1
`else
    localparam int LD_W        = DATA_W
`endif
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ0_VALID,
    output logic                   REQ0_READY,
    input  logic [ADDR_W-1:0]      REQ0_ADDR,
    input  logic [DATA_W-1:0]      REQ0_DATA,
    input  logic                   REQ1_VALID,
    output logic                   REQ1_READY,
    input  logic [ADDR_W-1:0]      REQ1_ADDR,
    input  logic [DATA_W-1:0]      REQ1_DATA,
    output logic [NUM_ENTRIES-1:0] LAT_E,
    output logic [LD_W-1:0]        LAT_D,
    output logic                   BUSY,
    output logic                   ADDR_ERR
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_ENTRIES);

    wr_state_e               state;
    logic                    idle;
    logic [1:0]              grant;
    logic                    accept;
    logic [ADDR_W-1:0]       addr_sel;
    logic [DATA_W-1:0]       data_sel;
    logic                    addr_ok;
    logic [ADDR_W-1:0]       addr_q;
    logic                    ok_q;
    logic [NUM_ENTRIES-1:0]  onehot;
    logic [LD_W-1:0]         d_next;

    assign idle = (state == IDLE);

    latq_bank_rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .valid  ({REQ1_VALID, REQ0_VALID} & {2{idle}}),
        .accept (accept),
        .grant  (grant)
    );

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];
    assign accept     = |grant;

    assign addr_sel = grant[1] ? REQ1_ADDR : REQ0_ADDR;
    assign data_sel = grant[1] ? REQ1_DATA : REQ0_DATA;
    assign addr_ok  = {1'b0, addr_sel} < LIMIT;

`ifdef LATQ_WR_PARITY_EN
    assign d_next = {^data_sel, data_sel};
`else
    assign d_next = data_sel;
`endif

    // Out-of-range addresses decode to all zeros so the strobe is suppressed
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            onehot[i] = ok_q && (addr_q == ADDR_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            LAT_E    <= '0;
            LAT_D    <= '0;
            BUSY     <= 1'b0;
            ADDR_ERR <= 1'b0;
            addr_q   <= '0;
            ok_q     <= 1'b0;
        end else begin
            ADDR_ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SETUP;
                        addr_q   <= addr_sel;
                        ok_q     <= addr_ok;
                        LAT_D    <= d_next;
                        ADDR_ERR <= !addr_ok;
                        BUSY     <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    LAT_E <= onehot;
                end
                STROBE: begin
                    state <= HOLD;
                    LAT_E <= '0;
                end
                HOLD: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    LAT_E <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latq_bank_wr_sched.sv
// Directed bench for latq_bank_wr_sched: an 8-entry instance and a 6-entry instance.
// Parity checks are compiled in when LATQ_WR_PARITY_EN is defined.
module tb_latq_bank_wr_sched;

`ifdef LATQ_WR_PARITY_EN
    localparam int LD_W = 9;
`else
    localparam int LD_W = 8;
`endif

    logic            CLK = 1'b0;
    logic            RST = 1'b1;

    logic            a_v0 = 0, a_v1 = 0, a_r0, a_r1;
    logic [2:0]      a_a0 = 0, a_a1 = 0;
    logic [7:0]      a_d0 = 0, a_d1 = 0;
    logic [7:0]      a_e;
    logic [LD_W-1:0] a_ld;
    logic            a_busy, a_err;

    logic            b_v0 = 0, b_v1 = 0, b_r0, b_r1;
    logic [2:0]      b_a0 = 0, b_a1 = 0;
    logic [7:0]      b_d0 = 0, b_d1 = 0;
    logic [5:0]      b_e;
    logic [LD_W-1:0] b_ld;
    logic            b_busy, b_err;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    latq_bank_wr_sched #(.NUM_ENTRIES(8), .DATA_W(8)) dut_a (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(a_v0), .REQ0_READY(a_r0), .REQ0_ADDR(a_a0), .REQ0_DATA(a_d0),
        .REQ1_VALID(a_v1), .REQ1_READY(a_r1), .REQ1_ADDR(a_a1), .REQ1_DATA(a_d1),
        .LAT_E(a_e), .LAT_D(a_ld), .BUSY(a_busy), .ADDR_ERR(a_err)
    );

    latq_bank_wr_sched #(.NUM_ENTRIES(6), .DATA_W(8)) dut_b (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(b_v0), .REQ0_READY(b_r0), .REQ0_ADDR(b_a0), .REQ0_DATA(b_d0),
        .REQ1_VALID(b_v1), .REQ1_READY(b_r1), .REQ1_ADDR(b_a1), .REQ1_DATA(b_d1),
        .LAT_E(b_e), .LAT_D(b_ld), .BUSY(b_busy), .ADDR_ERR(b_err)
    );

    function automatic logic [LD_W-1:0] exp_d(input logic [7:0] d);
`ifdef LATQ_WR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one write on dut_a: starts in IDLE with request already driven
    task automatic a_seq(input string tag, input logic [7:0] e, input logic [7:0] d);
        tick();
        chk({tag, "_setup_d"}, 64'(a_ld), 64'(exp_d(d)));
        chk({tag, "_setup_e"}, 64'(a_e), 64'h0);
        chk({tag, "_setup_busy"}, 64'(a_busy), 64'h1);
        tick();
        chk({tag, "_strobe_e"}, 64'(a_e), 64'(e));
        chk({tag, "_strobe_d"}, 64'(a_ld), 64'(exp_d(d)));
        tick();
        chk({tag, "_hold_e"}, 64'(a_e), 64'h0);
        chk({tag, "_hold_d"}, 64'(a_ld), 64'(exp_d(d)));
        tick();
        chk({tag, "_idle_busy"}, 64'(a_busy), 64'h0);
        chk({tag, "_idle_d"}, 64'(a_ld), 64'(exp_d(d)));
    endtask

    initial begin
        // reset
        RST = 1'b1;
        tick();
        tick();
        chk("rst_e", 64'(a_e), 64'h0);
        chk("rst_d", 64'(a_ld), 64'h0);
        chk("rst_busy", 64'(a_busy), 64'h0);
        chk("rst_err", 64'(a_err), 64'h0);
        RST = 1'b0;
        a_v0 = 1; a_a0 = 3; a_d0 = 8'hA5;
        #1;
        chk("rst_ready0", 64'(a_r0), 64'h1);
        chk("rst_ready1", 64'(a_r1), 64'h0);

        // single write, valid dropped right after accept
        @(posedge CLK);
        #1;
        a_v0 = 0;
        chk("w1_setup_d", 64'(a_ld), 64'(exp_d(8'hA5)));
        chk("w1_setup_e", 64'(a_e), 64'h0);
        chk("w1_ready_busy", 64'(a_r0), 64'h0);
        tick();
        chk("w1_strobe_e", 64'(a_e), 64'h08);
        tick();
        chk("w1_hold_e", 64'(a_e), 64'h0);
        chk("w1_hold_busy", 64'(a_busy), 64'h1);
        tick();
        chk("w1_idle_d", 64'(a_ld), 64'(exp_d(8'hA5)));
        chk("w1_idle_busy", 64'(a_busy), 64'h0);
        a_v0 = 1;
        #1;
        chk("w1_ready_again", 64'(a_r0), 64'h1);
        a_v0 = 0;

        // round robin from a fresh pointer
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        a_v0 = 1; a_a0 = 1; a_d0 = 8'h11;
        a_v1 = 1; a_a1 = 6; a_d1 = 8'h66;
        #1;
        chk("rr0_ready0", 64'(a_r0), 64'h1);
        chk("rr0_ready1", 64'(a_r1), 64'h0);
        a_seq("rr0", 8'h02, 8'h11);
        chk("rr1_ready0", 64'(a_r0), 64'h0);
        chk("rr1_ready1", 64'(a_r1), 64'h1);
        a_seq("rr1", 8'h40, 8'h66);
        chk("rr2_ready0", 64'(a_r0), 64'h1);
        chk("rr2_ready1", 64'(a_r1), 64'h0);
        a_seq("rr2", 8'h02, 8'h11);
        a_v0 = 0; a_v1 = 0;

        // reset during STROBE, then a fresh write from requester 1
        a_v0 = 1; a_a0 = 5; a_d0 = 8'h3C;
        tick();
        a_v0 = 0;
        tick();
        chk("mid_strobe_e", 64'(a_e), 64'h20);
        RST = 1'b1;
        tick();
        chk("mid_rst_e", 64'(a_e), 64'h0);
        chk("mid_rst_busy", 64'(a_busy), 64'h0);
        chk("mid_rst_d", 64'(a_ld), 64'h0);
        RST = 1'b0;
        a_v1 = 1; a_a1 = 2; a_d1 = 8'hC3;
        #1;
        chk("fresh_ready1", 64'(a_r1), 64'h1);
        @(posedge CLK);
        #1;
        a_v1 = 0;
        chk("fresh_setup_d", 64'(a_ld), 64'(exp_d(8'hC3)));
        tick();
        chk("fresh_strobe_e", 64'(a_e), 64'h04);
        tick();
        chk("fresh_hold_e", 64'(a_e), 64'h0);
        tick();
        chk("fresh_idle_busy", 64'(a_busy), 64'h0);

        // out-of-range address on the 6-entry instance
        chk("b_idle_busy", 64'(b_busy), 64'h0);
        b_v0 = 1; b_a0 = 7; b_d0 = 8'h55;
        @(posedge CLK);
        #1;
        b_v0 = 0;
        chk("b_setup_err", 64'(b_err), 64'h1);
        chk("b_setup_busy", 64'(b_busy), 64'h1);
        chk("b_setup_e", 64'(b_e), 64'h0);
        tick();
        chk("b_strobe_err", 64'(b_err), 64'h0);
        chk("b_strobe_e", 64'(b_e), 64'h0);
        chk("b_strobe_busy", 64'(b_busy), 64'h1);
        tick();
        chk("b_hold_e", 64'(b_e), 64'h0);
        chk("b_hold_busy", 64'(b_busy), 64'h1);
        tick();
        chk("b_idle_busy", 64'(b_busy), 64'h0);

        // in-range write on the 6-entry instance, top entry
        b_v1 = 1; b_a1 = 5; b_d1 = 8'h9E;
        @(posedge CLK);
        #1;
        b_v1 = 0;
        chk("b5_err", 64'(b_err), 64'h0);
        tick();
        chk("b5_strobe_e", 64'(b_e), 64'h20);
        tick();
        tick();

`ifdef LATQ_WR_PARITY_EN
        a_v0 = 1; a_a0 = 0; a_d0 = 8'h07;
        @(posedge CLK);
        #1;
        a_v0 = 0;
        chk("par_07", 64'(a_ld[8]), 64'h1);
        tick();
        tick();
        tick();
        a_v0 = 1; a_a0 = 0; a_d0 = 8'h03;
        @(posedge CLK);
        #1;
        a_v0 = 0;
        chk("par_03", 64'(a_ld[8]), 64'h0);
        tick();
        tick();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
